mul_sequencer: RTL
==================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter: MUL_LATENCY, default 9, clock cycles after the start pulse until mul_product is valid.
REQ-002 Parameter: ACC_W, default 24, width of out_data and the accumulator.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 areset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  sequencer accepts operands this cycle.
REQ-007 in_a, in_b  input  8 each  operands.
REQ-008 mul_a, mul_b  output  8 each  operands driven to multiplier8x8 A, B; registered.
REQ-009 mul_start  output  1  drives multiplier8x8 areset; one-cycle high pulse; registered.
REQ-010 mul_product  input  16  product from multiplier8x8.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_data  output  ACC_W  result.
REQ-014 acc_clear  input  1  clears accumulator; port exists only when MUL_ACC_EN is defined.

Function
REQ-015 FSM states: IDLE, START, WAIT, DONE.
REQ-016 IDLE: in_ready=1; in_valid=1 latches in_a/in_b into mul_a/mul_b and transitions to START.
REQ-017 START: mul_start=1 for exactly one cycle; load counter with MUL_LATENCY-1; transition to WAIT.
REQ-018 WAIT: counter decrements each cycle; at counter==0, capture mul_product into out_data and transition to DONE.
REQ-019 DONE: out_valid=1; out_data and mul_a/mul_b held stable until out_ready=1; then transition to IDLE.
REQ-020 in_ready=0 in START, WAIT, and DONE, and whenever areset=1; in_valid outside IDLE is ignored.
REQ-021 mul_a/mul_b remain constant from START through DONE.
REQ-022 Latency: acceptance cycle to out_valid rising = MUL_LATENCY+2 cycles; throughput one op per MUL_LATENCY+3 cycles minimum.
REQ-023 out_valid and out_ready high in the same cycle completes transfer; the next op may be accepted on the following cycle, with no combinational path from out_ready to in_ready.
REQ-024 MUL_LATENCY<1 is illegal; behaviour undefined.

Reset
REQ-025 areset=1 at a rising edge forces: state IDLE, out_valid=0, out_data=0, mul_a=0, mul_b=0, mul_start=0, counter=0, accumulator=0.
REQ-026 Reset in any state, including mid-WAIT, aborts the operation; no result is emitted for it.
REQ-027 First operand is accepted on the cycle after areset deasserts, at the earliest.

Configuration
REQ-028 Macro MUL_ACC_EN defined: at WAIT exit, accumulator = sat(accumulator + mul_product) at ACC_W bits, saturating at 2^ACC_W-1; out_data = new accumulator value.
REQ-029 MUL_ACC_EN defined: acc_clear=1 sets accumulator to 0; if coincident with capture, accumulator = mul_product; acc_clear does not affect a pending out_data.
REQ-030 MUL_ACC_EN undefined: out_data = mul_product zero-extended to ACC_W; no accumulator, no acc_clear port.

Verification
REQ-031 in_a=55, in_b=100 with ideal multiplier model, out_ready=1 -> out_data=5500, out_valid exactly MUL_LATENCY+2 cycles after acceptance, mul_start one cycle wide.
REQ-032 in_a=255, in_b=255 -> out_data=65025; in_a=1, in_b=0 -> out_data=0; in_a=1, in_b=1 -> out_data=1.
REQ-033 out_ready held 0 for 5 cycles in DONE -> out_valid=1, out_data stable, in_ready=0 throughout; a new in_valid in that window is not accepted.
REQ-034 areset pulsed mid-WAIT -> next cycle IDLE with all outputs 0; no out_valid for aborted op; next 55x100 yields 5500.
REQ-035 MUL_ACC_EN: 300 ops of 255x255 -> out_data saturates at 16777215; acc_clear then 1x1 -> out_data=1.

Source files
------------

// File: rtl/mul_sequencer.sv
// Sequencer for an external 8x8 multiplier: accepts an operand pair, pulses the
// multiplier start, waits MUL_LATENCY cycles and hands the product to a
// ready/valid consumer. Define MUL_ACC_EN to add a saturating accumulator.
`timescale 1ns/1ps

module mul_sequencer #(
  parameter int unsigned MUL_LATENCY = 9,
  parameter int unsigned ACC_W       = 24
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  output logic             mul_start,
  input  logic [15:0]      mul_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
`ifdef MUL_ACC_EN
  ,
  input  logic             acc_clear
`endif
);

  // Wide enough to hold MUL_LATENCY-1.
  localparam int unsigned CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         mul_a_q, mul_a_d;
  logic [7:0]         mul_b_q, mul_b_d;
  logic               mul_start_q, mul_start_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               accept;
  logic               capture;
  logic [ACC_W-1:0]   result;

  assign accept  = (state_q == IDLE) && in_valid;
  assign capture = (state_q == WAIT) && (cnt_q == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = START;
      START:                  state_d = WAIT;
      WAIT:    if (capture)   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. in_ready depends only on state and reset, never on out_ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE) && !areset;
    out_valid = (state_q == DONE);
    mul_start = mul_start_q;
    mul_a     = mul_a_q;
    mul_b     = mul_b_q;
    out_data  = out_data_q;
  end

  // ---------------------------------------------------------------------------
  // Result path
  // ---------------------------------------------------------------------------
`ifdef MUL_ACC_EN
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   acc_sum;

  // Assumes ACC_W >= 16 so the raw product always fits the accumulator.
  always_comb begin
    acc_sum = {1'b0, acc_q} + (ACC_W+1)'(mul_product);
    result  = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    if (acc_clear) begin
      result = ACC_W'(mul_product);
    end
    acc_d = acc_q;
    if (capture) begin
      acc_d = result;
    end else if (acc_clear) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  always_comb begin
    result = ACC_W'(mul_product);
  end
`endif

  // ---------------------------------------------------------------------------
  // Datapath next-state: operands, start pulse, latency counter, result
  // ---------------------------------------------------------------------------
  always_comb begin
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_start_d = 1'b0;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;

    // Operands are captured once and held until the next acceptance.
    if (accept) begin
      mul_a_d     = in_a;
      mul_b_d     = in_b;
      mul_start_d = 1'b1;
    end

    if (state_q == START) begin
      cnt_d = CNT_W'(MUL_LATENCY - 1);
    end else if ((state_q == WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (capture) begin
      out_data_d = result;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all datapath registers are small flops, so each gets an explicit
    // reset value; an aborted operation leaves nothing behind.
    if (areset) begin
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
    end else begin
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
